// File: rtl/vga_scanout.sv
// vga_scanout: VGA sync/blank timing, word-prefetch FIFO and pixel unpacker; define VGA_SCANOUT_UNDERFLOW_CNT_EN to build the underflowed-frame counter.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 11,
  parameter int V_SYNC = 2,
  parameter int V_BP = 31,
  parameter int PIX_W = 18,
  parameter int PIX_PER_WORD = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W = 18,
  localparam int MEM_W = PIX_W * PIX_PER_WORD,
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOT),
  localparam int VW = $clog2(V_TOT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic              frame_flag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [MEM_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [HW-1:0]     hcount,
  output logic [VW-1:0]     vcount,
  output logic              underflow,
  output logic [15:0]       underflow_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = PIX_PER_WORD > 1 ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] SUB_LAST = SW'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE / PIX_PER_WORD - 1);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state, state_n;
  logic [MEM_W-1:0] fifo [FIFO_DEPTH];
  logic [PIX_W-1:0] lane [PIX_PER_WORD];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [SW-1:0] sub;
  logic step, h_wrap, v_wrap, flush, active, empty, hit, pop, push;
  assign step = pix_ce && !frame_flag;
  assign h_wrap = hcount == H_LAST;
  assign v_wrap = h_wrap && vcount == V_LAST;
  assign flush = frame_flag || (step && v_wrap);
  assign active = hcount < H_ACT && vcount < V_ACT;
  assign empty = count == '0;
  assign hit = step && active && !underflow && !empty;
  assign pop = hit && sub == SUB_LAST;
  assign push = state == REQ && mem_done && !flush;
  assign mem_req = state != IDLE;
  for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_lane
    assign lane[k] = fifo[rd_ptr][MEM_W-1-k*PIX_W -: PIX_W];
  end
  // A request caught by a flush must still finish on the bus before its data can be dropped.
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (!flush && count < DEPTH) ? REQ : IDLE;
    else if (state == REQ) state_n = mem_done ? IDLE : flush ? DISCARD : REQ;
    else state_n = mem_done ? IDLE : DISCARD;
  end
  always_ff @(posedge clk) if (push) fifo[wr_ptr] <= mem_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mem_addr <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      sub <= '0;
      hcount <= '0;
      vcount <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
      pixel <= '0;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      // The address restart waits for an outstanding request so mem_addr stays stable under mem_req.
      if ((flush && !(mem_req && !mem_done)) || (state == DISCARD && mem_done)) mem_addr <= '0;
      else if (push) mem_addr <= mem_addr == ADDR_LAST ? '0 : mem_addr + 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        sub <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (hit) sub <= pop ? '0 : sub + 1'b1;
        count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
      if (frame_flag) begin
        hcount <= '0;
        vcount <= '0;
      end else if (pix_ce) begin
        hcount <= h_wrap ? '0 : hcount + 1'b1;
        if (h_wrap) vcount <= v_wrap ? '0 : vcount + 1'b1;
        hsync <= !(hcount >= HS_ON && hcount < HS_OFF);
        vsync <= !(vcount >= VS_ON && vcount < VS_OFF);
        blank <= !active;
        pixel <= hit ? lane[sub] : '0;
      end
      if (flush) underflow <= 1'b0;
      else if (step && active && empty) underflow <= 1'b1;
    end
  end
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underflow_count <= '0;
    else if (step && v_wrap && underflow && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 1'b1;
  end
`else
  assign underflow_count = '0;
`endif
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboarded check of a 7x5-slot timing with a 2-pixel word and 4-deep FIFO.
module tb_vga_scanout;
  logic clk, rst, pix_ce, frame_flag, mem_req, mem_done, hsync, vsync, blank, underflow;
  logic [3:0] mem_addr;
  logic [35:0] mem_data;
  logic [17:0] pixel;
  logic [2:0] hcount, vcount;
  logic [15:0] underflow_count;
  int errors = 0, checks = 0, served = 0, limit = 0, wait_cnt = 0, s0;
  int pix_tab [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
  localparam int UC_STEP = 1;
`else
  localparam int UC_STEP = 0;
`endif
  typedef struct {
    logic [17:0] pix;
    logic bl, hs, vs;
    int slot;
  } exp_t;
  exp_t sbq [$];

  vga_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_W(18), .PIX_PER_WORD(2), .FIFO_DEPTH(4), .ADDR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .frame_flag(frame_flag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .pixel(pixel), .hsync(hsync), .vsync(vsync), .blank(blank),
    .hcount(hcount), .vcount(vcount), .underflow(underflow), .underflow_count(underflow_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory answers one clock after it sees a request, serving words until served reaches limit.
  always @(negedge clk) begin
    if (rst) begin
      mem_done = 0;
      wait_cnt = 0;
    end else if (mem_done) mem_done = 0;
    else if (mem_req && served < limit) begin
      if (wait_cnt == 1) begin
        mem_done = 1;
        mem_data = {18'(mem_addr), 18'(mem_addr + 1)};
        served++;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  always @(posedge clk) begin
    if (pix_ce && !rst && sbq.size() > 0) begin
      exp_t e;
      #1;
      e = sbq.pop_front();
      chk($sformatf("pixel[s%0d]", e.slot), 36'(pixel), 36'(e.pix));
      chk($sformatf("blank[s%0d]", e.slot), 36'(blank), 36'(e.bl));
      chk($sformatf("hsync[s%0d]", e.slot), 36'(hsync), 36'(e.hs));
      chk($sformatf("vsync[s%0d]", e.slot), 36'(vsync), 36'(e.vs));
    end
  end

  task automatic run_slots(input int n, input int start, input bit starved);
    for (int i = 0; i < n; i++) begin
      int s = (start + i) % 35;
      int h = s % 7;
      int v = s / 7;
      exp_t e;
      e.slot = s;
      e.bl = !(h < 4 && v < 2);
      e.hs = h != 5;
      e.vs = v != 3;
      e.pix = (!e.bl && !starved) ? 18'(pix_tab[v * 4 + h]) : 18'd0;
      sbq.push_back(e);
      @(negedge clk) pix_ce = 1;
      @(negedge clk) pix_ce = 0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic wait_served(input int target, input string name);
    int n = 0;
    while (served < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 36'(served >= target), 36'd1);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_mem_req"}, 36'(mem_req), 36'd0);
    chk({tag, "_mem_addr"}, 36'(mem_addr), 36'd0);
    chk({tag, "_hcount"}, 36'(hcount), 36'd0);
    chk({tag, "_vcount"}, 36'(vcount), 36'd0);
    chk({tag, "_hsync"}, 36'(hsync), 36'd1);
    chk({tag, "_vsync"}, 36'(vsync), 36'd1);
    chk({tag, "_blank"}, 36'(blank), 36'd1);
    chk({tag, "_pixel"}, 36'(pixel), 36'd0);
    chk({tag, "_underflow"}, 36'(underflow), 36'd0);
    chk({tag, "_ucount"}, 36'(underflow_count), 36'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; pix_ce = 0; frame_flag = 0; mem_data = '0;
    repeat (3) @(negedge clk);
    reset_values("init");
    limit = 1000;
    rst = 0;
    repeat (30) @(negedge clk);
    chk("prefill_words", 36'(served), 36'd4);
    chk("prefill_req_low", 36'(mem_req), 36'd0);
    chk("prefill_addr_wrap", 36'(mem_addr), 36'd0);
    // Frame 1: FIFO prefilled, full pixel sequence checked.
    run_slots(1, 0, 0);
    chk("hcount_after_first", 36'(hcount), 36'd1);
    run_slots(20, 1, 0);
    chk("f1_no_underflow", 36'(underflow), 36'd0);
    chk("f1_hcount", 36'(hcount), 36'd0);
    chk("f1_vcount", 36'(vcount), 36'd3);
    run_slots(13, 21, 0);
    limit = served;
    run_slots(1, 34, 0);
    chk("wrap_hcount", 36'(hcount), 36'd0);
    chk("wrap_vcount", 36'(vcount), 36'd0);
    // Frames 2-4: memory stalled.
    run_slots(1, 0, 1);
    chk("stall_underflow_set", 36'(underflow), 36'd1);
    chk("stall_req_held", 36'(mem_req), 36'd1);
    chk("stall_addr", 36'(mem_addr), 36'd0);
    run_slots(34, 1, 1);
    chk("ucount_1", 36'(underflow_count), 36'(UC_STEP));
    chk("underflow_cleared", 36'(underflow), 36'd0);
    run_slots(70, 0, 1);
    chk("ucount_3", 36'(underflow_count), 36'(3 * UC_STEP));
    chk("stall_req_still", 36'(mem_req), 36'd1);
    // Let the discarded request finish; the refetch starts at word 0.
    limit = served + 1;
    wait_served(limit, "discard_done");
    repeat (3) @(negedge clk);
    chk("restart_req", 36'(mem_req), 36'd1);
    chk("restart_addr", 36'(mem_addr), 36'd0);
    limit = served + 2;
    wait_served(limit, "two_words");
    repeat (3) @(negedge clk);
    chk("req_addr2", 36'(mem_addr), 36'd2);
    chk("req_pending", 36'(mem_req), 36'd1);
    repeat (3) begin
      @(negedge clk) pix_ce = 1;
      @(negedge clk) pix_ce = 0;
    end
    chk("pre_flag_hcount", 36'(hcount), 36'd3);
    @(negedge clk) frame_flag = 1;
    @(negedge clk) frame_flag = 0;
    chk("flag_hcount", 36'(hcount), 36'd0);
    chk("flag_vcount", 36'(vcount), 36'd0);
    chk("flag_addr_held", 36'(mem_addr), 36'd2);
    limit = served + 1;
    wait_served(limit, "flag_discard");
    repeat (3) @(negedge clk);
    chk("flag_next_addr", 36'(mem_addr), 36'd0);
    chk("flag_next_req", 36'(mem_req), 36'd1);
    // Discarded word never reached the FIFO, so exactly FIFO_DEPTH words fit now.
    s0 = served;
    limit = s0 + 100;
    repeat (30) @(negedge clk);
    chk("depth_fill", 36'(served - s0), 36'd4);
    chk("depth_req_low", 36'(mem_req), 36'd0);
    run_slots(1, 0, 0);
    repeat (4) @(negedge clk);
    chk("no_pop_req_low", 36'(mem_req), 36'd0);
    chk("no_pop_words", 36'(served - s0), 36'd4);
    run_slots(1, 1, 0);
    repeat (8) @(negedge clk);
    chk("pop_refetch", 36'(served - s0), 36'd5);
    chk("refilled_req_low", 36'(mem_req), 36'd0);
    // Asynchronous reset in the middle of a line with pix_ce high.
    @(negedge clk) pix_ce = 1;
    repeat (4) @(negedge clk);
    chk("pre_reset_hcount", 36'(hcount), 36'd6);
    rst = 1;
    #1;
    reset_values("async");
    pix_ce = 0;
    @(negedge clk) rst = 0;
    @(negedge clk) pix_ce = 1;
    @(negedge clk) pix_ce = 0;
    chk("post_reset_hcount", 36'(hcount), 36'd1);
    chk("sb_drained", 36'(sbq.size()), 36'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine and successor to the fixed 640x480 writer. It combines a configurable sync/blank timing generator, a word-prefetch FIFO fed over the memory-interface request/done handshake, and a pixel unpacker that emits one PIX_W pixel per active pixel slot. It runs on a single system clock with a pixel clock-enable, which removes the two-clock ring buffers. It sits between the memory interface and the YCbCr-to-RGB converter/VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 11 / 2 / 31, vertical porch and sync widths in lines
- PIX_W, 18, bits per pixel (packed YCbCr 6/6/6)
- PIX_PER_WORD, 2, pixels per memory word; MEM_W = PIX_W*PIX_PER_WORD (derived)
- FIFO_DEPTH, 8, prefetch FIFO depth in words (power of two, ≥2)
- ADDR_W, 18, word-address width; must hold H_ACTIVE*V_ACTIVE/PIX_PER_WORD
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_ce  in  1  pixel-slot enable; timing advances only on cycles where it is high
- frame_flag  in  1  synchronous restart: counters to 0, FIFO flushed, fetch address to 0
- mem_req  out  1  word request, held until mem_done
- mem_addr  out  ADDR_W  word address, stable while mem_req is high
- mem_done  in  1  one-cycle strobe; mem_data valid this cycle
- mem_data  in  MEM_W  fetched word
- pixel  out  PIX_W  current pixel; 0 when blanked or after underflow
- hsync, vsync  out  1  active-low sync
- blank  out  1  high outside the active region
- hcount  out  log2(H total)  registered pixel counter
- vcount  out  log2(V total)  registered line counter
- underflow  out  1  sticky for the rest of the frame once the FIFO runs dry
- underflow_count  out  16  saturating count of underflowed frames

## Operation
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
- On pix_ce, hcount increments and wraps H_TOT-1→0. On that wrap, vcount increments and wraps V_TOT-1→0.
- Active when hcount<H_ACTIVE && vcount<V_ACTIVE.
- hsync is low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is low for vcount in the equivalent vertical window.
- Fetch FSM:
  - IDLE→REQ when FIFO count < FIFO_DEPTH and no flush is pending.
  - REQ keeps mem_req=1 until mem_done. On mem_done: push mem_data, increment mem_addr (wrapping to 0 after the last word of the frame), go to IDLE.
  - DISCARD is entered from REQ on a flush. It waits for mem_done, drops the data, then goes to IDLE.
  - mem_done in IDLE or DISCARD never pushes.
- Unpacker:
  - Pixels are emitted most-significant first: pixel k of a word = mem_data[MEM_W-1-k*PIX_W -: PIX_W].
  - A word is popped on the pix_ce that emits its last pixel.
  - A simultaneous push and pop leaves the count unchanged.
- Underflow:
  - If the FIFO is empty when an active slot needs a word, underflow is set and pixel is 0 for the rest of the frame.
  - At the vcount wrap V_TOT-1→0, underflow clears, the FIFO flushes, mem_addr is set to 0, and a pending request goes to DISCARD. The display resynchronises each frame.
- frame_flag has the same flush effect and also zeroes hcount and vcount. frame_flag has priority over pix_ce in the same cycle.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0, FSM=IDLE, FIFO empty.
  - hcount=0, vcount=0.
  - hsync=1, vsync=1, blank=1, pixel=0.
  - underflow=0, underflow_count=0.
- pixel, hsync, vsync and blank are registered on pix_ce and reflect the counter values of the previous pix_ce: a 1-slot latency, all mutually aligned.
- mem_req is registered. It rises one clock after the FIFO has room and drops the clock after mem_done.
- The minimum request period is 2 clocks, so at most one request is outstanding.
- Bandwidth requirement: mem_done latency must average below PIX_PER_WORD pix_ce periods per word to avoid underflow.
- Reset mid-request drops the transaction. The memory side must tolerate mem_req falling without mem_done.

## Configuration
- VGA_SCANOUT_UNDERFLOW_CNT_EN
  - Defined: underflow_count increments once per frame in which underflow was set, evaluated at the frame wrap, and saturates at 16'hFFFF.
  - Undefined: underflow_count is constant 0 and no counter logic is built.
  - The underflow flag itself exists in both builds.

## Test plan
- Reset mid-frame with pix_ce=1 → all outputs at reset values in the same cycle. After release, hcount reads 1 after the first pix_ce.
- Small timing (H 4/1/1/1, V 2/1/1/1, PIX_PER_WORD 2) with memory answering 1 clock after request, word n = {n,n+1} → pixel sequence 0,1,1,2 on line 0 and 2,3,3,4 on line 1.
  - hsync is low exactly at hcount 5 (output 1 slot later).
  - blank=1 on slots 4–6.
- Memory stalls, never asserting mem_done → mem_req stays high with a stable mem_addr.
  - underflow rises at the first active slot and pixel stays 0 for the frame.
  - Next frame: mem_addr restarts at 0 after mem_done arrives and the discard completes.
- frame_flag while in REQ → the next mem_done is discarded (FIFO count stays 0), the following request uses mem_addr=0, and hcount/vcount are 0.
- FIFO_DEPTH=4 with always-ready memory during blanking → exactly 4 words pushed and mem_req low until the first pop.
- With VGA_SCANOUT_UNDERFLOW_CNT_EN: three consecutive starved frames → underflow_count=3. Without the macro it stays 0.
